pc_redirect_ctrl: RTL and testbench

Control block that drives the program counter's update inputs: `PCsrc`, `isBranch`, `holdPC`, `PCoffset` and `jVal`.
- Resolves taken branches and jumps in EX and rewrites the branch offset relative to the already-advanced PC.
- Stalls fetch on load-use hazards and instruction-memory wait.
- Squashes wrong-path instructions with a small flush state machine.
- Sits between the EX/hazard logic and the PC register in the pipelined core.

---
 rtl/pc_redirect_pkg.sv | 14 +
 rtl/pc_redirect_stats.sv | 35 +++
 rtl/pc_redirect_ctrl.sv | 115 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_pkg.sv
// Shared types and constants for the PC redirect controller.
// Holds the FSM state encoding, the PC step size and the default datapath width.
package pc_redirect_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int PC_STEP      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/pc_redirect_stats.sv
// Saturating redirect / held-PC cycle counters for the PC redirect controller.
// Counts update on the clock edge and hold at all-ones; synchronous clear on rst.
module pc_redirect_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic        hold_i,
  output logic [31:0] redirect_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (redirect_i && (redirect_cnt_q != 32'hFFFF_FFFF)) redirect_cnt_d = redirect_cnt_q + 32'd1;
    if (hold_i && (stall_cnt_q != 32'hFFFF_FFFF))        stall_cnt_d    = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Drives the PC update controls: EX redirects, load-use stall, fetch wait, wrong-path squash.
// Optional statistics counters are enabled with the PC_REDIRECT_STATS_EN macro.
module pc_redirect_ctrl
  import pc_redirect_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int PC_LAG       = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_branch,
  input  logic            ex_cond,
  input  logic [XLEN-1:0] ex_offset,
  input  logic            ex_jump,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ld_use,
  input  logic            imem_ready,
  output logic            PCsrc,
  output logic            isBranch,
  output logic            holdPC,
  output logic [XLEN-1:0] PCoffset,
  output logic [XLEN-1:0] jVal,
  output logic            if_id_flush,
  output logic            id_ex_bubble
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  // The PC has already advanced PC_LAG instructions past the branch by the time we redirect.
  localparam logic [XLEN-1:0] BR_ADJ = XLEN'(PC_STEP * PC_LAG);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             redirect;

  assign redirect = ex_jump | (ex_branch & ex_cond);

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    PCsrc        = 1'b0;
    isBranch     = 1'b0;
    holdPC       = 1'b0;
    PCoffset     = '0;
    jVal         = '0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE, STALL: begin
          if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (ex_jump) begin
              PCsrc = 1'b1;
              jVal  = ex_target;
            end else begin
              isBranch = 1'b1;
              PCoffset = ex_offset - BR_ADJ;
            end
            state_d = FLUSH;
            fcnt_d  = FLUSH_LAST;
          end else if ((state_q == IDLE) && ld_use) begin
            holdPC       = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = STALL;
          end else begin
            holdPC  = !imem_ready;
            state_d = IDLE;
          end
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          holdPC       = !imem_ready;
          if (fcnt_q == '0) state_d = IDLE;
          else              fcnt_d  = fcnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  logic redirect_cyc;
  // A flush raised outside FLUSH is by construction the redirect cycle itself.
  assign redirect_cyc = if_id_flush && (state_q != FLUSH);

  pc_redirect_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .redirect_i     (redirect_cyc),
    .hold_i         (holdPC),
    .redirect_cnt_o (redirect_cnt),
    .stall_cnt_o    (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed vector table plus randomized cycles against a reference model.
module tb_pc_redirect_ctrl;

  typedef struct packed {
    logic        rst, br, cond;
    logic [31:0] off;
    logic        jmp;
    logic [31:0] tgt;
    logic        ld, rdy;
  } vin_t;

  typedef struct packed {
    logic        pcsrc, isbr, hold;
    logic [31:0] pcoff, jval;
    logic        flush, bub;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  localparam int NVEC = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ex_branch, ex_cond, ex_jump, ld_use, imem_ready;
  logic [31:0] ex_offset, ex_target;

  logic        pcsrc1, isbr1, hold1, flush1, bub1;
  logic [31:0] pcoff1, jval1;
  logic        pcsrc3, isbr3, hold3, flush3, bub3;
  logic [31:0] pcoff3, jval3;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] rcnt1, scnt1, rcnt3, scnt3;
`endif

  pc_redirect_ctrl dut (
    .clk(clk), .rst(rst), .ex_branch(ex_branch), .ex_cond(ex_cond), .ex_offset(ex_offset),
    .ex_jump(ex_jump), .ex_target(ex_target), .ld_use(ld_use), .imem_ready(imem_ready),
    .PCsrc(pcsrc1), .isBranch(isbr1), .holdPC(hold1), .PCoffset(pcoff1), .jVal(jval1),
    .if_id_flush(flush1), .id_ex_bubble(bub1)
`ifdef PC_REDIRECT_STATS_EN
    , .redirect_cnt(rcnt1), .stall_cnt(scnt1)
`endif
  );

  pc_redirect_ctrl #(.XLEN(32), .PC_LAG(3), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .ex_branch(ex_branch), .ex_cond(ex_cond), .ex_offset(ex_offset),
    .ex_jump(ex_jump), .ex_target(ex_target), .ld_use(ld_use), .imem_ready(imem_ready),
    .PCsrc(pcsrc3), .isBranch(isbr3), .holdPC(hold3), .PCoffset(pcoff3), .jVal(jval3),
    .if_id_flush(flush3), .id_ex_bubble(bub3)
`ifdef PC_REDIRECT_STATS_EN
    , .redirect_cnt(rcnt3), .stall_cnt(scnt3)
`endif
  );

  vout_t got1, got3;
  assign got1 = {pcsrc1, isbr1, hold1, pcoff1, jval1, flush1, bub1};
  assign got3 = {pcsrc3, isbr3, hold3, pcoff3, jval3, flush3, bub3};

  int checks = 0;
  int errors = 0;

  // Reference model state: squash cycles still owed, and whether last cycle was a load-use stall.
  int m1_squash = 0, m3_squash = 0;
  bit m1_after_ld = 0, m3_after_ld = 0;

  function automatic vin_t vi(logic r, logic b, logic c, logic [31:0] o, logic j,
                              logic [31:0] t, logic l, logic y);
    vin_t v;
    v = {r, b, c, o, j, t, l, y};
    return v;
  endfunction

  function automatic vout_t vo(logic ps, logic ib, logic h, logic [31:0] po,
                               logic [31:0] jv, logic f, logic bb);
    vout_t v;
    v = {ps, ib, h, po, jv, f, bb};
    return v;
  endfunction

  task automatic model(input vin_t v, input int fc, input int lag, inout int squash,
                       inout bit after_ld, output vout_t o);
    o = '0;
    if (v.rst) begin
      squash   = 0;
      after_ld = 0;
    end else if (squash > 0) begin
      o.flush = 1; o.bub = 1; o.hold = !v.rdy;
      squash  = squash - 1;
      after_ld = 0;
    end else if (v.jmp || (v.br && v.cond)) begin
      o.flush = 1; o.bub = 1;
      if (v.jmp) begin
        o.pcsrc = 1; o.jval = v.tgt;
      end else begin
        o.isbr = 1; o.pcoff = v.off - 32'(4 * lag);
      end
      squash   = fc;
      after_ld = 0;
    end else if (v.ld && !after_ld) begin
      o.hold = 1; o.bub = 1;
      after_ld = 1;
    end else begin
      o.hold   = !v.rdy;
      after_ld = 0;
    end
  endtask

  task automatic chk(input string name, input vout_t got, input vout_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got src=%0d br=%0d hold=%0d off=%h jv=%h fl=%0d bub=%0d want src=%0d br=%0d hold=%0d off=%h jv=%h fl=%0d bub=%0d",
               name, got.pcsrc, got.isbr, got.hold, got.pcoff, got.jval, got.flush, got.bub,
               exp.pcsrc, exp.isbr, exp.hold, exp.pcoff, exp.jval, exp.flush, exp.bub);
    end
  endtask

  // Drive one cycle, sample mid-cycle; the table expectation is used when given, else the model.
  task automatic step(input string name, input vin_t v, input bit use_tbl, input vout_t tbl_exp);
    vout_t e1, e3;
    @(posedge clk);
    #1;
    rst = v.rst; ex_branch = v.br; ex_cond = v.cond; ex_offset = v.off;
    ex_jump = v.jmp; ex_target = v.tgt; ld_use = v.ld; imem_ready = v.rdy;
    @(negedge clk);
    model(v, 1, 2, m1_squash, m1_after_ld, e1);
    model(v, 3, 3, m3_squash, m3_after_ld, e3);
    chk(name, got1, use_tbl ? tbl_exp : e1);
    chk({name, "_lag3"}, got3, e3);
  endtask

  vec_t tbl [NVEC];
  vin_t rv;

  initial begin
    rst = 1; ex_branch = 0; ex_cond = 0; ex_offset = '0; ex_jump = 0; ex_target = '0;
    ld_use = 0; imem_ready = 1;

    tbl[0]  = {vi(1,0,0,32'h0,1,32'h0,1,1),        vo(0,0,0,32'h0,32'h0,0,0)};
    tbl[1]  = {vi(1,0,0,32'h0,1,32'h0,1,1),        vo(0,0,0,32'h0,32'h0,0,0)};
    tbl[2]  = {vi(0,0,0,32'h0,0,32'h0,0,1),        vo(0,0,0,32'h0,32'h0,0,0)};
    tbl[3]  = {vi(0,1,1,32'h20,0,32'h0,0,1),       vo(0,1,0,32'h18,32'h0,1,1)};
    tbl[4]  = {vi(0,0,0,32'h0,1,32'h40,0,1),       vo(0,0,0,32'h0,32'h0,1,1)};
    tbl[5]  = {vi(0,0,0,32'h0,0,32'h0,0,1),        vo(0,0,0,32'h0,32'h0,0,0)};
    tbl[6]  = {vi(0,1,1,32'hFFFFFFF0,0,32'h0,0,1), vo(0,1,0,32'hFFFFFFE8,32'h0,1,1)};
    tbl[7]  = {vi(0,0,0,32'h0,0,32'h0,0,1),        vo(0,0,0,32'h0,32'h0,1,1)};
    tbl[8]  = {vi(0,1,0,32'hFFFFFFF0,0,32'h0,0,1), vo(0,0,0,32'h0,32'h0,0,0)};
    tbl[9]  = {vi(0,1,1,32'h8,1,32'h100,1,0),      vo(1,0,0,32'h0,32'h100,1,1)};
    tbl[10] = {vi(0,0,0,32'h0,0,32'h0,1,1),        vo(0,0,0,32'h0,32'h0,1,1)};
    tbl[11] = {vi(0,0,0,32'h0,0,32'h0,1,1),        vo(0,0,1,32'h0,32'h0,0,1)};
    tbl[12] = {vi(0,0,0,32'h0,0,32'h0,1,1),        vo(0,0,0,32'h0,32'h0,0,0)};
    tbl[13] = {vi(0,0,0,32'h0,0,32'h0,0,1),        vo(0,0,0,32'h0,32'h0,0,0)};
    tbl[14] = {vi(0,0,0,32'h0,0,32'h0,0,0),        vo(0,0,1,32'h0,32'h0,0,0)};
    tbl[15] = {vi(0,0,0,32'h0,0,32'h0,0,0),        vo(0,0,1,32'h0,32'h0,0,0)};
    tbl[16] = {vi(0,0,0,32'h0,0,32'h0,0,0),        vo(0,0,1,32'h0,32'h0,0,0)};
    tbl[17] = {vi(0,0,0,32'h0,0,32'h0,1,1),        vo(0,0,1,32'h0,32'h0,0,1)};
    tbl[18] = {vi(0,1,1,32'h8,0,32'h0,1,0),        vo(0,1,0,32'h0,32'h0,1,1)};
    tbl[19] = {vi(1,0,0,32'h0,0,32'h0,0,1),        vo(0,0,0,32'h0,32'h0,0,0)};
    tbl[20] = {vi(0,0,0,32'h0,0,32'h0,0,1),        vo(0,0,0,32'h0,32'h0,0,0)};
    tbl[21] = {vi(0,0,0,32'h0,1,32'h4,0,1),        vo(1,0,0,32'h0,32'h4,1,1)};
    tbl[22] = {vi(0,0,0,32'h0,0,32'h0,0,0),        vo(0,0,1,32'h0,32'h0,1,1)};
    tbl[23] = {vi(0,0,0,32'h0,0,32'h0,0,1),        vo(0,0,0,32'h0,32'h0,0,0)};

    for (int k = 0; k < NVEC; k++) begin
      step($sformatf("vec%0d", k), tbl[k].i, 1'b1, tbl[k].o);
    end

    for (int n = 0; n < 600; n++) begin
      rv.rst  = ($urandom_range(0, 39) == 0);
      rv.jmp  = ($urandom_range(0, 7) == 0);
      rv.br   = ($urandom_range(0, 3) == 0);
      rv.cond = $urandom_range(0, 1) == 1;
      rv.off  = $urandom;
      rv.tgt  = $urandom;
      rv.ld   = ($urandom_range(0, 3) == 0);
      rv.rdy  = ($urandom_range(0, 3) != 0);
      step($sformatf("rnd%0d", n), rv, 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
